gpio_led_sw_btn_irq: RTL and testbench

Parametrised IPIF slave that succeeds the fixed 8-LED/8-switch peripheral. It drives C_NUM_LED LEDs and reads C_NUM_SW switches plus C_NUM_BTN push-buttons through synchronisers and debouncers. It adds byte-enable writes, atomic LED set and clear registers, per-input change interrupts and a registered read/write handshake with error reporting. It sits behind the standard IPIF user_logic slot and drives the board pins and one interrupt line.

---
 rtl/gpio_led_sw_btn_irq_if.sv | 22 ++
 rtl/gpio_led_sw_btn_irq.sv | 163 ++++++++++++++++
 tb/tb_gpio_led_sw_btn_irq.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_led_sw_btn_irq_if.sv
// IPIF user_logic slot: CE-decoded read/write strobes towards the slave and the
// registered data/ack/error return path.
interface gpio_led_sw_btn_irq_if;
  logic [31:0] Bus2IP_Data;
  logic [3:0]  Bus2IP_BE;
  logic [5:0]  Bus2IP_RdCE;
  logic [5:0]  Bus2IP_WrCE;
  logic [31:0] IP2Bus_Data;
  logic        IP2Bus_RdAck;
  logic        IP2Bus_WrAck;
  logic        IP2Bus_Error;

  modport master (
    output Bus2IP_Data, Bus2IP_BE, Bus2IP_RdCE, Bus2IP_WrCE,
    input  IP2Bus_Data, IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error
  );

  modport slave (
    input  Bus2IP_Data, Bus2IP_BE, Bus2IP_RdCE, Bus2IP_WrCE,
    output IP2Bus_Data, IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error
  );
endinterface

// File: rtl/gpio_led_sw_btn_irq.sv
// LED/switch/button GPIO slave: byte-enabled LED register with atomic set/clear,
// debounced inputs, per-input change interrupts and a one-ack-per-access handshake.
module gpio_led_sw_btn_irq #(
  parameter int C_NUM_LED         = 8,
  parameter int C_NUM_SW          = 8,
  parameter int C_NUM_BTN         = 5,
  parameter int C_DEBOUNCE_CYCLES = 1000000,
  parameter int C_NUM_REG         = 6,
  parameter int C_SLV_DWIDTH      = 32
) (
  input  logic                  Bus2IP_Clk,
  input  logic                  Bus2IP_Reset,
  gpio_led_sw_btn_irq_if.slave  bus,
  output logic [C_NUM_LED-1:0]  led,
  input  logic [C_NUM_SW-1:0]   sw,
  input  logic [C_NUM_BTN-1:0]  btn,
  output logic                  irq
);

  localparam int N  = C_NUM_SW + C_NUM_BTN;
  localparam int CW = $clog2(C_DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(C_DEBOUNCE_CYCLES - 1);

  // CE bit positions: the MSB selects word offset 0x00
  localparam int CE_LED_DATA  = 5;
  localparam int CE_LED_SET   = 4;
  localparam int CE_LED_CLR   = 3;
  localparam int CE_IN_STATUS = 2;
  localparam int CE_IRQ_PEND  = 1;
  localparam int CE_IRQ_EN    = 0;

  typedef enum logic {ST_IDLE, ST_BUSY} bus_state_e;

  bus_state_e                state_q, state_d;
  logic [C_NUM_REG-1:0]      rd_ce, wr_ce;
  logic [2*C_NUM_REG-1:0]    all_ce;
  logic                      any_ce, start, acc_err, wr_ok, rd_ok;
  logic [C_SLV_DWIDTH-1:0]   be_mask, wdata_m, rdata_d, rdata_q;
  logic                      rd_ack_q, wr_ack_q, err_q;

  logic [C_NUM_LED-1:0]      led_q, led_d;
  logic [N-1:0]              en_q, en_d, pend_q, pend_d, w1c;
  logic                      gie_q, gie_d, irq_q, irq_d;

  logic [N-1:0]              sync1_q, sync2_q, stable_q, stable_d, stable_dly_q;
  logic [CW-1:0]             cnt_q [N];
  logic [CW-1:0]             cnt_d [N];

  logic                      unused_wdata;
  assign unused_wdata = ^wdata_m;

  assign rd_ce   = bus.Bus2IP_RdCE;
  assign wr_ce   = bus.Bus2IP_WrCE;
  assign all_ce  = {rd_ce, wr_ce};
  assign any_ce  = |all_ce;
  assign start   = any_ce && (state_q == ST_IDLE);
  assign acc_err = !$onehot(all_ce) || wr_ce[CE_IN_STATUS];
  assign wr_ok   = start && (|wr_ce) && !acc_err;
  assign rd_ok   = start && (|rd_ce) && !acc_err;

  // Busy holds from the first CE cycle until every CE bit has dropped.
  always_comb begin
    state_d = any_ce ? ST_BUSY : ST_IDLE;
  end

  always_ff @(posedge Bus2IP_Clk) begin
    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    if (Bus2IP_Reset) state_q <= ST_IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    be_mask = '0;
    for (int b = 0; b < C_SLV_DWIDTH / 8; b++) be_mask[8*b +: 8] = {8{bus.Bus2IP_BE[b]}};
    wdata_m = bus.Bus2IP_Data & be_mask;

    led_d = led_q;
    en_d  = en_q;
    gie_d = gie_q;
    w1c   = '0;
    if (wr_ok) begin
      if (wr_ce[CE_LED_DATA]) led_d = (led_q & ~be_mask[C_NUM_LED-1:0]) | wdata_m[C_NUM_LED-1:0];
      if (wr_ce[CE_LED_SET])  led_d = led_q | wdata_m[C_NUM_LED-1:0];
      if (wr_ce[CE_LED_CLR])  led_d = led_q & ~wdata_m[C_NUM_LED-1:0];
      if (wr_ce[CE_IRQ_PEND]) w1c   = wdata_m[N-1:0];
      if (wr_ce[CE_IRQ_EN]) begin
        en_d = (en_q & ~be_mask[N-1:0]) | wdata_m[N-1:0];
        if (bus.Bus2IP_BE[3]) gie_d = wdata_m[C_SLV_DWIDTH-1];
      end
    end

    // A hardware edge in the same cycle as a W1C keeps the bit set.
    pend_d = (pend_q & ~w1c) | (stable_q ^ stable_dly_q);
    irq_d  = gie_q & (|(pend_q & en_q));

    rdata_d = '0;
    if (rd_ok) begin
      if (rd_ce[CE_LED_DATA])  rdata_d = C_SLV_DWIDTH'(led_q);
      if (rd_ce[CE_IN_STATUS]) rdata_d = C_SLV_DWIDTH'(stable_q);
      if (rd_ce[CE_IRQ_PEND])  rdata_d = C_SLV_DWIDTH'(pend_q);
      if (rd_ce[CE_IRQ_EN]) begin
        rdata_d = C_SLV_DWIDTH'(en_q);
        rdata_d[C_SLV_DWIDTH-1] = gie_q;
      end
    end
  end

  // Debounce: accept a new level only after it has differed for C_DEBOUNCE_CYCLES samples.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) stable_d[i] = sync2_q[i];
        else                     cnt_d[i]    = cnt_q[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge Bus2IP_Clk) begin
    if (Bus2IP_Reset) begin
      led_q        <= '0;
      en_q         <= '0;
      gie_q        <= 1'b0;
      pend_q       <= '0;
      irq_q        <= 1'b0;
      rdata_q      <= '0;
      rd_ack_q     <= 1'b0;
      wr_ack_q     <= 1'b0;
      err_q        <= 1'b0;
      sync1_q      <= '0;
      sync2_q      <= '0;
      stable_q     <= '0;
      stable_dly_q <= '0;
      // NOTE: the counter array is reset too, so a level held through reset is re-qualified from zero.
      cnt_q        <= '{default: '0};
    end else begin
      led_q        <= led_d;
      en_q         <= en_d;
      gie_q        <= gie_d;
      pend_q       <= pend_d;
      irq_q        <= irq_d;
      rdata_q      <= rdata_d;
      rd_ack_q     <= start && (|rd_ce);
      wr_ack_q     <= start && (|wr_ce);
      err_q        <= start && acc_err;
      sync1_q      <= {btn, sw};
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.IP2Bus_Data  = rdata_q;
  assign bus.IP2Bus_RdAck = rd_ack_q;
  assign bus.IP2Bus_WrAck = wr_ack_q;
  assign bus.IP2Bus_Error = err_q;
  assign led              = led_q;
  assign irq              = irq_q;

endmodule

// File: tb/tb_gpio_led_sw_btn_irq.sv
// Bench for gpio_led_sw_btn_irq: directed register/debounce/irq scenarios plus random
// traffic, every cycle compared against a behavioural model of the register map.
module tb_gpio_led_sw_btn_irq;
  localparam int NL = 8, NS = 8, NB = 5, N = NS + NB, DC = 4;
  localparam int R_LED = 0, R_SET = 1, R_CLR = 2, R_IN = 3, R_PEND = 4, R_EN = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NL-1:0] led;
  logic [NS-1:0] sw  = '0;
  logic [NB-1:0] btn = '0;
  logic          irq;
  logic          mon_on = 1'b0;

  gpio_led_sw_btn_irq_if bus_if();

  gpio_led_sw_btn_irq #(
    .C_NUM_LED(NL), .C_NUM_SW(NS), .C_NUM_BTN(NB), .C_DEBOUNCE_CYCLES(DC),
    .C_NUM_REG(6), .C_SLV_DWIDTH(32)
  ) dut (
    .Bus2IP_Clk(clk), .Bus2IP_Reset(rst), .bus(bus_if),
    .led(led), .sw(sw), .btn(btn), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [NL-1:0] m_led;
  logic [N-1:0]  m_en, m_pend, m_stable, m_stable_prev;
  logic          m_gie, m_irq, m_busy, m_rdack, m_wrack, m_err;
  logic [31:0]   m_rdata;
  logic [N-1:0]  pin_hist [$];  // pin samples of the last DC+2 edges, oldest first

  function automatic logic [31:0] mask_of(input logic [3:0] be);
    logic [31:0] m = '0;
    for (int b = 0; b < 4; b++) if (be[b]) m[8*b +: 8] = 8'hFF;
    return m;
  endfunction

  always @(posedge clk) begin
    logic [5:0]   rd, wr;
    logic [31:0]  wd;
    logic [N-1:0] chg, w1c, nxt;
    logic         start, err, irq_n, flip;
    int           r;
    if (rst) begin
      m_led = '0; m_en = '0; m_gie = 0; m_pend = '0; m_irq = 0; m_busy = 0;
      m_rdack = 0; m_wrack = 0; m_err = 0; m_rdata = '0;
      m_stable = '0; m_stable_prev = '0;
      pin_hist = {};
      repeat (DC + 2) pin_hist.push_back('0);
    end else begin
      chg   = m_stable ^ m_stable_prev;
      irq_n = m_gie & (|(m_pend & m_en));
      rd    = bus_if.Bus2IP_RdCE;
      wr    = bus_if.Bus2IP_WrCE;
      start = (|{rd, wr}) && !m_busy;
      m_busy = |{rd, wr};
      err   = ($countones({rd, wr}) != 1) || wr[5 - R_IN];
      m_rdack = start && (|rd);
      m_wrack = start && (|wr);
      m_err   = start && err;
      m_rdata = '0;
      w1c     = '0;
      wd      = bus_if.Bus2IP_Data & mask_of(bus_if.Bus2IP_BE);
      if (start && !err) begin
        r = 0;
        for (int k = 0; k < 6; k++) if (rd[k] || wr[k]) r = 5 - k;
        if (|rd) begin
          case (r)
            R_LED:  m_rdata = 32'(m_led);
            R_IN:   m_rdata = 32'(m_stable);
            R_PEND: m_rdata = 32'(m_pend);
            R_EN:   m_rdata = {m_gie, 31'(m_en)};
            default: m_rdata = '0;
          endcase
        end else begin
          case (r)
            R_LED:  m_led = (m_led & ~mask_of(bus_if.Bus2IP_BE)) | wd;
            R_SET:  m_led = m_led | wd[NL-1:0];
            R_CLR:  m_led = m_led & ~wd[NL-1:0];
            R_PEND: w1c = wd[N-1:0];
            R_EN: begin
              m_en = (m_en & ~mask_of(bus_if.Bus2IP_BE)) | wd[N-1:0];
              if (bus_if.Bus2IP_BE[3]) m_gie = wd[31];
            end
            default: ;
          endcase
        end
      end
      m_pend = (m_pend & ~w1c) | chg;
      m_irq  = irq_n;
      // The debouncer sees each pin two edges late; a flip needs DC consecutive differing samples.
      pin_hist.push_back({btn, sw});
      void'(pin_hist.pop_front());
      nxt = m_stable;
      for (int i = 0; i < N; i++) begin
        flip = 1'b1;
        for (int k = 0; k < DC; k++) if (pin_hist[k][i] == m_stable[i]) flip = 1'b0;
        if (flip) nxt[i] = ~m_stable[i];
      end
      m_stable_prev = m_stable;
      m_stable      = nxt;
    end
  end

  always @(posedge clk) begin
    #1;
    if (mon_on) begin
      check("mon_led",   32'(led), 32'(m_led));
      check("mon_irq",   32'(irq), 32'(m_irq));
      check("mon_rdack", 32'(bus_if.IP2Bus_RdAck), 32'(m_rdack));
      check("mon_wrack", 32'(bus_if.IP2Bus_WrAck), 32'(m_wrack));
      check("mon_err",   32'(bus_if.IP2Bus_Error), 32'(m_err));
      check("mon_rdata", bus_if.IP2Bus_Data, m_rdata);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    bus_if.Bus2IP_RdCE = '0;
    bus_if.Bus2IP_WrCE = '0;
    bus_if.Bus2IP_Data = '0;
    bus_if.Bus2IP_BE   = '0;
  endtask

  task automatic access(input logic [5:0] rd, input logic [5:0] wr, input logic [31:0] d,
                        input logic [3:0] be, input int hold, output logic [31:0] rdata,
                        output logic err, output int acks);
    bus_if.Bus2IP_RdCE = rd;
    bus_if.Bus2IP_WrCE = wr;
    bus_if.Bus2IP_Data = d;
    bus_if.Bus2IP_BE   = be;
    tick();
    rdata = bus_if.IP2Bus_Data;
    err   = bus_if.IP2Bus_Error;
    acks  = int'(bus_if.IP2Bus_RdAck) + int'(bus_if.IP2Bus_WrAck);
    for (int i = 1; i < hold; i++) begin
      tick();
      acks += int'(bus_if.IP2Bus_RdAck) + int'(bus_if.IP2Bus_WrAck);
    end
    bus_idle();
    tick();
    acks += int'(bus_if.IP2Bus_RdAck) + int'(bus_if.IP2Bus_WrAck);
  endtask

  task automatic reg_wr(input string tag, input int r, input logic [31:0] d,
                        input logic [3:0] be, input int hold);
    logic [31:0] rdata;
    logic        err;
    int          acks;
    access(6'd0, 6'd1 << (5 - r), d, be, hold, rdata, err, acks);
    check({tag, "_wack"}, 32'(acks), 32'd1);
    check({tag, "_werr"}, 32'(err), 32'd0);
  endtask

  task automatic reg_rd(input string tag, input int r, input logic [31:0] exp, input int hold);
    logic [31:0] rdata;
    logic        err;
    int          acks;
    access(6'd1 << (5 - r), 6'd0, 32'hDEAD_BEEF, 4'hF, hold, rdata, err, acks);
    check(tag, rdata, exp);
    check({tag, "_rack"}, 32'(acks), 32'd1);
    check({tag, "_rerr"}, 32'(err), 32'd0);
  endtask

  initial begin
    logic [31:0] rdata;
    logic        err;
    int          acks;
    logic [5:0]  rd, wr;

    bus_idle();
    repeat (3) tick();
    check("rst_led",  32'(led), 32'h0);
    check("rst_irq",  32'(irq), 32'h0);
    check("rst_ack",  32'(bus_if.IP2Bus_RdAck | bus_if.IP2Bus_WrAck | bus_if.IP2Bus_Error), 32'h0);
    rst = 1'b0;
    mon_on = 1'b1;
    tick();

    // 1: full-word LED write, CE held 3 cycles still gives one ack each way
    reg_wr("t1_wr", R_LED, 32'h0000_00A5, 4'hF, 3);
    check("t1_led", 32'(led), 32'hA5);
    reg_rd("t1_rd", R_LED, 32'h0000_00A5, 3);

    // 2: atomic set/clear, write-only reads, BE=0 write
    reg_wr("t2_set", R_SET, 32'h0F, 4'hF, 1);
    check("t2_led_set", 32'(led), 32'hAF);
    reg_wr("t2_clr", R_CLR, 32'h81, 4'hF, 1);
    check("t2_led_clr", 32'(led), 32'h2E);
    reg_rd("t2_rd_set", R_SET, 32'h0, 1);
    reg_rd("t2_rd_clr", R_CLR, 32'h0, 1);
    reg_wr("t2_be0", R_LED, 32'hFF, 4'h0, 1);
    check("t2_led_be0", 32'(led), 32'h2E);

    // 3: sw[3] becomes visible exactly 6 edges after the pin changes
    sw[3] = 1'b1;
    repeat (5) tick();
    access(6'b000100, 6'd0, 32'h0, 4'hF, 1, rdata, err, acks);
    check("t3_early", 32'(rdata[3]), 32'd0);
    reg_rd("t3_in", R_IN, 32'h8, 1);
    btn[0] = 1'b1;
    repeat (3) tick();
    btn[0] = 1'b0;
    repeat (10) tick();
    reg_rd("t3_glitch", R_IN, 32'h8, 1);
    reg_rd("t3_pend", R_PEND, 32'h8, 1);

    // 4: interrupt path
    reg_wr("t4_clrall", R_PEND, 32'h1FFF, 4'hF, 1);
    reg_rd("t4_pend0", R_PEND, 32'h0, 1);
    reg_wr("t4_en", R_EN, 32'h8000_0008, 4'hF, 1);
    sw[3] = 1'b0;
    repeat (12) tick();
    reg_rd("t4_pend", R_PEND, 32'h8, 1);
    check("t4_irq1", 32'(irq), 32'd1);
    reg_wr("t4_w1c", R_PEND, 32'h8, 4'hF, 1);
    check("t4_irq0", 32'(irq), 32'd0);
    repeat (4) tick();
    reg_rd("t4_no_reset", R_PEND, 32'h0, 1);
    sw[3] = 1'b1;
    repeat (12) tick();
    check("t4_irq_again", 32'(irq), 32'd1);
    reg_wr("t4_gie_off", R_EN, 32'h0000_0008, 4'hF, 1);
    check("t4_irq_gie0", 32'(irq), 32'd0);
    reg_rd("t4_pend_kept", R_PEND, 32'h8, 1);
    reg_rd("t4_en_rd", R_EN, 32'h0000_0008, 1);

    // 5: error accesses
    access(6'd0, 6'b000100, 32'hFFFF_FFFF, 4'hF, 1, rdata, err, acks);
    check("t5_wr_in_err", 32'(err), 32'd1);
    check("t5_wr_in_ack", 32'(acks), 32'd1);
    reg_rd("t5_in_kept", R_IN, 32'h8, 1);
    access(6'b110000, 6'd0, 32'h0, 4'hF, 2, rdata, err, acks);
    check("t5_multi_err", 32'(err), 32'd1);
    check("t5_multi_data", rdata, 32'h0);
    check("t5_led_kept", 32'(led), 32'h2E);

    // 6: reset during a write-CE cycle
    reg_wr("t6_ff", R_LED, 32'hFF, 4'h1, 1);
    bus_if.Bus2IP_WrCE = 6'b100000;
    bus_if.Bus2IP_Data = 32'h55;
    bus_if.Bus2IP_BE   = 4'hF;
    rst = 1'b1;
    tick();
    check("t6_led", 32'(led), 32'h0);
    check("t6_wack", 32'(bus_if.IP2Bus_WrAck), 32'd0);
    check("t6_irq", 32'(irq), 32'd0);
    rst = 1'b0;
    bus_idle();
    tick();
    reg_rd("t6_en", R_EN, 32'h0, 1);
    reg_rd("t6_led_rd", R_LED, 32'h0, 1);

    // random traffic, all outputs compared every cycle against the model
    for (int it = 0; it < 600; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        sw  = 8'($urandom);
        btn = 5'($urandom);
      end
      if ($urandom_range(0, 9) == 0) begin
        rd = 6'($urandom);
        wr = 6'($urandom);
      end else begin
        rd = '0;
        wr = '0;
        if ($urandom_range(0, 1) == 0) rd = 6'd1 << $urandom_range(0, 5);
        else                           wr = 6'd1 << $urandom_range(0, 5);
      end
      access(rd, wr, $urandom, 4'($urandom), int'($urandom_range(1, 3)), rdata, err, acks);
      repeat ($urandom_range(0, 6)) tick();
      if ($urandom_range(0, 149) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
    end

    mon_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
